// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle for stream_rr_arbiter: N request streams in,
// one arbitrated stream out.
interface stream_rr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int WORD_WIDTH = 8,
  parameter int SRC_W      = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]            s_valid;
  logic [NUM_PORTS-1:0]            s_ready;
  logic [NUM_PORTS*WORD_WIDTH-1:0] s_data;
  logic [NUM_PORTS-1:0]            s_last;
  logic                            m_valid;
  logic                            m_ready;
  logic [WORD_WIDTH-1:0]           m_data;
  logic                            m_last;
  logic [SRC_W-1:0]                m_src;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_src
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_src
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin stream arbiter with a two-entry
// registered output stage (no m_ready -> s_ready path).
module stream_rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int WORD_WIDTH = 8,
  parameter int SRC_W      = $clog2(NUM_PORTS)
) (
  input logic                clk,
  input logic                rst,
  stream_rr_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                state;
  logic [SRC_W-1:0]      g;
  logic [SRC_W-1:0]      last_grant;
  logic [SRC_W-1:0]      pick;
  logic                  found;
  int                    idx;
  logic [1:0]            count;
  logic                  room;
  logic                  push;
  logic                  pop;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_last;
  logic [WORD_WIDTH-1:0] h_data;
  logic                  h_last;
  logic [SRC_W-1:0]      h_src;
  logic [WORD_WIDTH-1:0] k_data;
  logic                  k_last;
  logic [SRC_W-1:0]      k_src;

  assign room    = count != 2'd2;
  assign in_data = bus.s_data[g*WORD_WIDTH +: WORD_WIDTH];
  assign in_last = bus.s_last[g];
  assign push    = (state == LOCKED) && room && bus.s_valid[g];
  assign pop     = (count != 2'd0) && bus.m_ready;

  always_comb begin
    bus.s_ready = '0;
    if (state == LOCKED && room)
      bus.s_ready[g] = 1'b1;
  end

  // first requester after last_grant, wrapping
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last_grant) + k) % NUM_PORTS;
      if (!found && bus.s_valid[idx]) begin
        found = 1'b1;
        pick  = SRC_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      g          <= '0;
      last_grant <= SRC_W'(NUM_PORTS - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state <= LOCKED;
            g     <= pick;
          end
        end
        LOCKED: begin
          if (push && in_last) begin
            state      <= IDLE;
            last_grant <= g;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      h_data <= '0;
      h_last <= 1'b0;
      h_src  <= '0;
      k_data <= '0;
      k_last <= 1'b0;
      k_src  <= '0;
    end else begin
      unique case (1'b1)
        push && !pop: begin
          count <= count + 2'd1;
          if (count == 2'd0) begin
            h_data <= in_data;
            h_last <= in_last;
            h_src  <= g;
          end else begin
            k_data <= in_data;
            k_last <= in_last;
            k_src  <= g;
          end
        end
        pop && !push: begin
          count  <= count - 2'd1;
          h_data <= k_data;
          h_last <= k_last;
          h_src  <= k_src;
        end
        push && pop: begin
          if (count == 2'd1) begin
            h_data <= in_data;
            h_last <= in_last;
            h_src  <= g;
          end else begin
            h_data <= k_data;
            h_last <= k_last;
            h_src  <= k_src;
            k_data <= in_data;
            k_last <= in_last;
            k_src  <= g;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_valid = count != 2'd0;
  assign bus.m_data  = h_data;
  assign bus.m_last  = h_last;
  assign bus.m_src   = h_src;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: random sources, a
// packet-level arbitration model and an output monitor.
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  stream_rr_arbiter_if #(
    .NUM_PORTS (N),
    .WORD_WIDTH(W)
  ) bus ();

  stream_rr_arbiter #(
    .NUM_PORTS (N),
    .WORD_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    int           src;
  } beat_t;

  beat_t q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(
    input int           lastg,
    input logic [N-1:0] v
  );
    for (int k = 1; k <= N; k++)
      if (v[(lastg + k) % N]) return (lastg + k) % N;
    return -1;
  endfunction

  // packet-level model: who owns the output, how full the stage is
  bit           m_idle = 1'b1;
  int           m_g    = 0;
  int           m_lastg = N - 1;
  int           m_occ  = 0;
  logic [N-1:0] er;
  bit           acc;
  bit           popm;

  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      q.delete();
      m_idle  = 1'b1;
      m_g     = 0;
      m_lastg = N - 1;
      m_occ   = 0;
    end else begin
      er = '0;
      if (!m_idle && m_occ != 2) er[m_g] = 1'b1;
      chk("s_ready", 32'(bus.s_ready), 32'(er));
      acc  = !m_idle && m_occ != 2 && bus.s_valid[m_g];
      popm = m_occ != 0 && bus.m_ready;
      if (acc)
        q.push_back('{bus.s_data[m_g*W +: W],
                      bus.s_last[m_g], m_g});
      m_occ = m_occ + int'(acc) - int'(popm);
      if (m_idle) begin
        if (bus.s_valid != '0) begin
          m_idle = 1'b0;
          m_g    = rr_pick(m_lastg, bus.s_valid);
        end
      end else if (acc && bus.s_last[m_g]) begin
        m_idle  = 1'b1;
        m_lastg = m_g;
      end
    end
  end

  beat_t e;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("m_valid", 32'(bus.m_valid), 32'(q.size() != 0));
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL m_beat: got data %0h expected none",
                   bus.m_data);
        end else begin
          e = q.pop_front();
          chk("m_data", 32'(bus.m_data), 32'(e.d));
          chk("m_last", 32'(bus.m_last), 32'(e.l));
          chk("m_src", 32'(bus.m_src), 32'(e.src));
        end
      end
    end
  end

  int           beat[N];
  int           len[N];
  logic [W-1:0] dat[N];

  task automatic new_pkt(input int i, input int mn, input int mx);
    beat[i] = 0;
    len[i]  = $urandom_range(mx, mn);
    dat[i]  = W'($urandom);
  endtask

  task automatic run(
    input int           cycles,
    input logic [N-1:0] mask,
    input int           start_pct,
    input int           bub_pct,
    input int           mr_pct,
    input int           mn,
    input int           mx,
    input int           rst_at
  );
    logic [N-1:0] fire;
    bit           was_rst;
    bit           act;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      fire    = bus.s_valid & bus.s_ready;
      was_rst = rst;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (was_rst) begin
          new_pkt(i, mn, mx);
        end else if (fire[i]) begin
          beat[i]++;
          dat[i] = W'($urandom);
          if (beat[i] == len[i]) new_pkt(i, mn, mx);
        end
      end
      rst = (c == rst_at);
      for (int i = 0; i < N; i++) begin
        if (beat[i] > 0)
          act = $urandom_range(99, 0) >= bub_pct;
        else
          act = mask[i] && ($urandom_range(99, 0) < start_pct);
        bus.s_valid[i]         = act;
        bus.s_last[i]          = beat[i] == len[i] - 1;
        bus.s_data[i*W +: W]   = dat[i];
      end
      bus.m_ready = $urandom_range(99, 0) < mr_pct;
    end
  endtask

  initial begin
    bus.s_valid = '0;
    bus.s_last  = '0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < N; i++) new_pkt(i, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_m_src", 32'(bus.m_src), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(20, 4'b0100, 100, 0, 100, 3, 3, -1);
    run(60, 4'b1111, 100, 0, 100, 2, 2, -1);
    run(60, 4'b1010, 100, 40, 100, 3, 5, -1);
    run(200, 4'b1111, 60, 30, 100, 1, 6, -1);
    run(200, 4'b1111, 70, 20, 50, 1, 6, -1);
    run(40, 4'b1111, 100, 0, 30, 4, 4, -1);
    run(30, 4'b0001, 100, 0, 100, 4, 4, 6);
    run(100, 4'b0011, 100, 0, 100, 1, 1, -1);
    run(300, 4'b1111, 50, 25, 60, 1, 5, 150);
    run(60, 4'b0000, 0, 0, 100, 1, 1, -1);
    chk("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin, packet-locked arbiter that shares one valid/ready output stream among `NUM_PORTS` requesting streams. It sits in front of a shared downstream consumer, such as a pipeline stage or register slice chain. It keeps each packet contiguous on the output. It registers its output through a two-entry skid stage, so no combinational path exists from `m_ready` to any `s_ready`.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters; must be ≥2.
- `WORD_WIDTH`, 8: data width per beat.
- `SRC_W`, `$clog2(NUM_PORTS)`: width of the source index (derived).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `s_valid`  in  NUM_PORTS  per-port beat valid.
- `s_ready`  out  NUM_PORTS  per-port ready; at most one bit high.
- `s_data`  in  NUM_PORTS*WORD_WIDTH  port i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
- `s_last`  in  NUM_PORTS  final beat of a packet.
- `m_valid`  out  1  output beat valid (registered).
- `m_ready`  in  1  downstream ready.
- `m_data`  out  WORD_WIDTH  output beat.
- `m_last`  out  1  final beat of the output packet.
- `m_src`  out  SRC_W  index of the port that supplied the beat.

## Operation
- **FSM states:**
  - IDLE: no grant; all `s_ready`=0.
  - LOCKED: grant register `g` is valid.
- **IDLE → LOCKED:**
  - Taken when any `s_valid` bit is high.
  - `g` = first requesting port searching `last_grant+1, last_grant+2, …` modulo `NUM_PORTS`.
  - The decision uses only that cycle's `s_valid`.
- **Behaviour in LOCKED:**
  - `s_ready[g]` = (`count` != 2). All other `s_ready` bits are 0.
  - A beat is accepted when `s_valid[g]` && `s_ready[g]`.
  - The accepted beat stores {`s_data[g]`, `s_last[g]`, `g`} into the output stage.
- **LOCKED → IDLE:**
  - Taken on acceptance of a beat with `s_last[g]`=1.
  - `last_grant` <= `g` on that transition.
- **Lock hold:**
  - The lock holds while `s_valid[g]` is low mid-packet (bubbles).
  - Other requesters wait and are never interleaved.
- **Output stage:**
  - Two entries, head and skid, with a registered `count` in 0..2.
  - `m_valid` = (`count` != 0); `m_data`/`m_last`/`m_src` come from the head entry.
  - Accept with `m_valid && m_ready` pops the head; the skid entry moves to head.
  - A simultaneous push and pop keeps `count` unchanged and preserves FIFO order.
- **Reset values:**
  - State IDLE, `last_grant`=`NUM_PORTS`-1 (port 0 has first priority), `count`=0.
  - Outputs: `s_ready`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `m_src`=0.
- **Reset mid-packet:**
  - Lock, grant and both buffered entries are discarded.
  - The bench must not expect those beats at the output.

## Timing
- **Arbitration latency:** request first seen in IDLE at cycle t → LOCKED and `s_ready[g]` high at cycle t+1, given `count`<2.
- **Data latency:** beat accepted at edge k → visible on `m_valid`/`m_data` after edge k, i.e. in cycle k+1 when the stage was empty.
- **Throughput:**
  - Within a packet: 1 beat/cycle while `m_ready`=1.
  - Between packets: one mandatory IDLE cycle, so a packet of L beats occupies ≥ L+1 cycles.
- **Backpressure:**
  - `m_ready`=0 for one cycle fills the skid entry (`count`=2); `s_ready[g]` drops the following cycle.
  - No beat is lost or duplicated.
- **Release after last beat:** `s_ready[g]` falls in the cycle after the last beat is accepted, because the state is then IDLE.
- **Single-beat packets:** `s_last`=1 on the first beat is legal; lock is taken for exactly that beat.
- **Fairness:** with all ports continuously requesting, grants cycle 0,1,2,3,0,… .

## Test plan
- **Single port:**
  - Stimulus: reset; port 2 sends a 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3) with `m_ready`=1.
  - Required response: `s_ready[2]` rises 1 cycle after `s_valid[2]`. Output is 0xA1..0xA3 on consecutive cycles with `m_src`=2 and `m_last` only on 0xA3. `s_ready`=0 the cycle after.
- **Round-robin:**
  - Stimulus: all 4 ports hold 2-beat packets tagged 0x10·i+k; `m_ready`=1.
  - Required response: output order is port 0,1,2,3,0. No interleaving within a packet. One idle cycle between packets.
- **Packet lock:**
  - Stimulus: port 1 holds its grant and drops `s_valid` for 3 cycles mid-packet while port 3 requests.
  - Required response: port 3 gets no `s_ready` until port 1's last beat is accepted, then port 3 is granted next.
- **Backpressure:**
  - Stimulus: `m_ready` toggles 1,0,0,1,1 during a 4-beat packet.
  - Required response: `count` reaches 2 and `s_ready` deasserts. The output sequence is intact, with no duplicates.
- **Reset mid-packet:**
  - Stimulus: assert `rst` for 1 cycle after 2 of 4 beats are accepted from port 0.
  - Required response: the next cycle shows `m_valid`=0 and `s_ready`=0, and the next grant goes to port 0 (`last_grant` is reset).
- **Single-beat packets:**
  - Stimulus: ports 0 and 1 send continuous 1-beat packets.
  - Required response: grants alternate 0,1,0,1 and output is 1 beat per 2 cycles.
